mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Two-client request arbiter and response router directly upstream of the core's memory interface.
- Clients are port 0 (instruction fetch) and port 1 (data memory stage). The block merges their read/write requests into the single memory-interface request port and registers one accepted request per cycle.
- It tracks in-flight reads in a latency pipeline and returns each read response to the port that issued it.

Parameters:
- CORE, 0, core index printed in report output
- DATA_WIDTH, 32, data word width
- ADDRESS_BITS, 20, address width
- READ_LATENCY, 1, cycles from mem_read asserted to mem_out_data valid (legal 1..4)

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- p0_read, p0_write  input  1 each  port 0 request strobes, held until accepted
- p0_address  input  ADDRESS_BITS  port 0 request address
- p0_in_data  input  DATA_WIDTH  port 0 write data
- p0_ready  output  1  combinational; request accepted at this edge
- p0_valid  output  1  one-cycle read-response strobe
- p0_out_data  output  DATA_WIDTH  read response data
- p0_out_addr  output  ADDRESS_BITS  address of the returned read
- p1_*  same seven signals for port 1
- mem_read, mem_write  output  1 each  to memory interface
- mem_address  output  ADDRESS_BITS  to memory interface
- mem_in_data  output  DATA_WIDTH  to memory interface
- mem_out_data  input  DATA_WIDTH  from memory interface
- report  input  1  when high, $display state every cycle

Behaviour:
- Reset values (immediate on reset=0):
  - mem_read=0, mem_write=0, mem_address=0, mem_in_data=0
  - p0_valid=p1_valid=0, p0/p1_out_data=0, p0/p1_out_addr=0
  - response pipeline cleared; last_grant=1, so port 0 wins first contention
- Request: port X is requesting when pX_read|pX_write. If both strobes are high, the request is a write and the read is ignored.
- Arbitration (combinational, round-robin):
  - One requester: it is granted.
  - Both requesting: the port not equal to last_grant is granted.
  - pX_ready = grant to X. At most one ready per cycle. pX_ready=0 when X is not requesting.
  - On each grant, last_grant <= granted port; otherwise unchanged.
- Issue register: on the edge where a grant occurs, mem_read/mem_write/mem_address/mem_in_data load the granted request. With no grant they load 0. Strobes are therefore high for exactly one cycle per accepted request.
- Response pipeline: READ_LATENCY+1 stages of {valid, port, address}.
  - Stage 0 loads {mem_read, port, mem_address}, aligned with issue.
  - When the tail stage is valid, mem_out_data is captured into p<port>_out_data, p<port>_out_addr <= tail address, and p<port>_valid <= 1 for one cycle.
  - The other port's valid is 0 that cycle; its out_data/out_addr hold their previous values.
- Latency: with acceptance at edge A, mem_read is high in cycle A+1 and pX_valid is high in cycle A+READ_LATENCY+2. Example: READ_LATENCY=1 gives valid in the 3rd cycle after acceptance.
- Writes produce no response strobe.
- Throughput: one request per cycle, unlimited outstanding reads. The memory interface never back-pressures. Responses return in issue order.
- Back-to-back reads from alternating ports return in the same alternating order on consecutive cycles.
- Read-after-write to the same address, accepted on consecutive edges, returns the new data. This relies on the issue order to memory.
- Reset asserted mid-operation: all in-flight reads are dropped, no valid strobe is produced, and arbitration restarts with port 0 priority.
- READ_LATENCY outside 1..4: simulation $display error at time 0.
- report: print a cycle count (reset to 0), the grant, mem_* signals and pipeline occupancy.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then 1 with no requests -> all outputs 0, no ready, no valid for 20 cycles.
- Single read: p0_read=1, p0_address=0x00010, memory holds 0xDEADBEEF, READ_LATENCY=1 -> p0_ready=1 at first edge; mem_read=1 for one cycle with mem_address=0x00010; p0_valid=1 two cycles later with data 0xDEADBEEF, p0_out_addr=0x00010; p1_valid stays 0.
- Contention: both ports read every cycle for 6 cycles (p0 addr 0x4, p1 addr 0x8) -> grants 0,1,0,1,0,1; responses alternate p0/p1 on 6 consecutive cycles with correct data.
- Write then read: p1_write addr 0x20 data 0x12345678, then p1_read addr 0x20 on the next cycle -> no valid for the write; the read returns 0x12345678.
- Reset mid-flight: accept a p0 read, pull reset low on the next cycle -> p0_valid never asserts; after release, p0 wins a simultaneous request.
- Latency sweep: READ_LATENCY=3, single p1 read -> p1_valid exactly 5 cycles after the acceptance edge.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-port round-robin request arbiter feeding a single memory interface.
// In-flight reads are tagged in a pipeline and returned to their issuing port.
module mem_req_arbiter #(
    parameter int unsigned CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    p0_read,
    input  logic                    p0_write,
    input  logic [ADDRESS_BITS-1:0] p0_address,
    input  logic [DATA_WIDTH-1:0]   p0_in_data,
    output logic                    p0_ready,
    output logic                    p0_valid,
    output logic [DATA_WIDTH-1:0]   p0_out_data,
    output logic [ADDRESS_BITS-1:0] p0_out_addr,

    input  logic                    p1_read,
    input  logic                    p1_write,
    input  logic [ADDRESS_BITS-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0]   p1_in_data,
    output logic                    p1_ready,
    output logic                    p1_valid,
    output logic [DATA_WIDTH-1:0]   p1_out_data,
    output logic [ADDRESS_BITS-1:0] p1_out_addr,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,

    input  logic                    report
);

    localparam int unsigned STAGES = READ_LATENCY + 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("mem_req_arbiter: READ_LATENCY %0d outside legal range 1..4", READ_LATENCY);
    end

    typedef struct packed {
        logic                    valid;
        logic                    port;
        logic [ADDRESS_BITS-1:0] address;
    } rsp_tag_t;

    logic                    req0;
    logic                    req1;
    logic                    grant0;
    logic                    grant1;
    logic                    last_grant;
    logic                    sel_read;
    logic                    sel_write;
    logic [ADDRESS_BITS-1:0] sel_address;
    logic [DATA_WIDTH-1:0]   sel_data;
    rsp_tag_t [STAGES-1:0]   pipe;
    rsp_tag_t                tail;

    // Round-robin: on contention the port that did not win last time is granted.
    always_comb begin
        req0   = p0_read | p0_write;
        req1   = p1_read | p1_write;
        grant0 = req0 & (~req1 | last_grant);
        grant1 = req1 & (~req0 | ~last_grant);
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Granted request payload; a simultaneous read+write strobe is a write.
    always_comb begin
        sel_read    = 1'b0;
        sel_write   = 1'b0;
        sel_address = '0;
        sel_data    = '0;
        if (grant0) begin
            sel_write   = p0_write;
            sel_read    = p0_read & ~p0_write;
            sel_address = p0_address;
            sel_data    = p0_in_data;
        end else if (grant1) begin
            sel_write   = p1_write;
            sel_read    = p1_read & ~p1_write;
            sel_address = p1_address;
            sel_data    = p1_in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_in_data <= '0;
            last_grant  <= 1'b1;
        end else begin
            mem_read    <= sel_read;
            mem_write   <= sel_write;
            mem_address <= sel_address;
            mem_in_data <= sel_data;
            if (grant0 | grant1) begin
                last_grant <= grant1;
            end
        end
    end

    // Stage 0 is loaded alongside the issue register; the tail lines up with mem_out_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: sel_read, port: grant1, address: sel_address};
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p0_valid    <= 1'b0;
            p0_out_data <= '0;
            p0_out_addr <= '0;
            p1_valid    <= 1'b0;
            p1_out_data <= '0;
            p1_out_addr <= '0;
        end else begin
            p0_valid <= tail.valid & ~tail.port;
            p1_valid <= tail.valid & tail.port;
            if (tail.valid && !tail.port) begin
                p0_out_data <= mem_out_data;
                p0_out_addr <= tail.address;
            end
            if (tail.valid && tail.port) begin
                p1_out_data <= mem_out_data;
                p1_out_addr <= tail.address;
            end
        end
    end

`ifndef SYNTHESIS
    logic [31:0]       report_cycle;
    logic [STAGES-1:0] pipe_valid;

    always_comb begin
        pipe_valid = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            pipe_valid[i] = pipe[i].valid;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            report_cycle <= '0;
        end else begin
            report_cycle <= report_cycle + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (report) begin
            $display("core %0d cycle %0d grant %b%b rd %b wr %b addr %h wdata %h occupancy %0d",
                     CORE, report_cycle, grant1, grant0, mem_read, mem_write,
                     mem_address, mem_in_data, $countones(pipe_valid));
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: READ_LATENCY 1 and 3 instances share stimulus
// and are checked every cycle against a transaction-level model.
module tb_mem_req_arbiter;

    localparam logic [31:0] POISON = 32'hBAD0_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        report = 1'b0;
    logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
    logic [19:0] p0_address = '0, p1_address = '0;
    logic [31:0] p0_in_data = '0, p1_in_data = '0;

    logic        p0_ready_1, p0_valid_1, p1_ready_1, p1_valid_1, mem_read_1, mem_write_1;
    logic [31:0] p0_out_data_1, p1_out_data_1, mem_in_data_1, mem_out_data_1;
    logic [19:0] p0_out_addr_1, p1_out_addr_1, mem_address_1;
    logic        p0_ready_3, p0_valid_3, p1_ready_3, p1_valid_3, mem_read_3, mem_write_3;
    logic [31:0] p0_out_data_3, p1_out_data_3, mem_in_data_3, mem_out_data_3;
    logic [19:0] p0_out_addr_3, p1_out_addr_3, mem_address_3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    mem_req_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .READ_LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address), .p0_in_data(p0_in_data),
        .p0_ready(p0_ready_1), .p0_valid(p0_valid_1), .p0_out_data(p0_out_data_1), .p0_out_addr(p0_out_addr_1),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address), .p1_in_data(p1_in_data),
        .p1_ready(p1_ready_1), .p1_valid(p1_valid_1), .p1_out_data(p1_out_data_1), .p1_out_addr(p1_out_addr_1),
        .mem_read(mem_read_1), .mem_write(mem_write_1), .mem_address(mem_address_1),
        .mem_in_data(mem_in_data_1), .mem_out_data(mem_out_data_1), .report(report)
    );

    mem_req_arbiter #(.CORE(1), .DATA_WIDTH(32), .ADDRESS_BITS(20), .READ_LATENCY(3)) u_lat3 (
        .clock(clock), .reset(reset),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address), .p0_in_data(p0_in_data),
        .p0_ready(p0_ready_3), .p0_valid(p0_valid_3), .p0_out_data(p0_out_data_3), .p0_out_addr(p0_out_addr_3),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address), .p1_in_data(p1_in_data),
        .p1_ready(p1_ready_3), .p1_valid(p1_valid_3), .p1_out_data(p1_out_data_3), .p1_out_addr(p1_out_addr_3),
        .mem_read(mem_read_3), .mem_write(mem_write_3), .mem_address(mem_address_3),
        .mem_in_data(mem_in_data_3), .mem_out_data(mem_out_data_3), .report(report)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            32'h10:  return 32'hDEAD_BEEF;
            32'h04:  return 32'hA0A0_0004;
            32'h08:  return 32'hB0B0_0008;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    // Memory stand-ins: fixed-latency read data, poison when no read is in flight.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] line_a;
    logic [31:0] line_b [3];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = init_word(i);
            mem_b[i] = init_word(i);
        end
    end

    always @(posedge clock) begin
        if (mem_write_1) mem_a[mem_address_1[7:0]] = mem_in_data_1;
        line_a <= mem_read_1 ? mem_a[mem_address_1[7:0]] : POISON;
        if (mem_write_3) mem_b[mem_address_3[7:0]] = mem_in_data_3;
        line_b[0] <= mem_read_3 ? mem_b[mem_address_3[7:0]] : POISON;
        line_b[1] <= line_b[0];
        line_b[2] <= line_b[1];
    end

    assign mem_out_data_1 = line_a;
    assign mem_out_data_3 = line_b[2];

    // Reference model: accepted reads become scheduled responses, writes update a shadow memory.
    typedef struct {
        int          acc;
        logic        port;
        logic [19:0] addr;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] ref_mem [256];
    int          m_cyc = 0;
    logic        m_last = 1'b1;
    logic        e_mem_read = 1'b0, e_mem_write = 1'b0;
    logic [19:0] e_mem_address = '0;
    logic [31:0] e_mem_in_data = '0;
    logic        e_valid [2][2];
    logic [31:0] e_data  [2][2];
    logic [19:0] e_addr  [2][2];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                e_valid[k][p] = 1'b0;
                e_data[k][p]  = '0;
                e_addr[k][p]  = '0;
            end
    end

    function automatic logic [1:0] grant_of(input logic rq0, input logic rq1, input logic lastg);
        if (rq0 && rq1) return lastg ? 2'b01 : 2'b10;
        return {rq1, rq0};
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [1:0]  g;
        logic        port;
        logic        w;
        logic        r;
        logic [19:0] a;
        logic [31:0] d;
        int          lat;
        if (!reset) begin
            m_last = 1'b1;
            pend.delete();
            e_mem_read = 1'b0; e_mem_write = 1'b0; e_mem_address = '0; e_mem_in_data = '0;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    e_valid[k][p] = 1'b0;
                    e_data[k][p]  = '0;
                    e_addr[k][p]  = '0;
                end
        end else begin
            g = grant_of(p0_read | p0_write, p1_read | p1_write, m_last);
            m_cyc++;
            e_mem_read = 1'b0; e_mem_write = 1'b0; e_mem_address = '0; e_mem_in_data = '0;
            if (g != 2'b00) begin
                port = g[1];
                w = port ? p1_write : p0_write;
                r = port ? p1_read : p0_read;
                a = port ? p1_address : p0_address;
                d = port ? p1_in_data : p0_in_data;
                e_mem_write = w;
                e_mem_read = r & ~w;
                e_mem_address = a;
                e_mem_in_data = d;
                m_last = port;
                if (w) ref_mem[a[7:0]] = d;
                else pend.push_back('{acc: m_cyc, port: port, addr: a, data: ref_mem[a[7:0]]});
            end
            for (int k = 0; k < 2; k++) begin
                lat = (k == 0) ? 1 : 3;
                e_valid[k][0] = 1'b0;
                e_valid[k][1] = 1'b0;
                foreach (pend[i]) begin
                    if (pend[i].acc + lat + 1 == m_cyc) begin
                        e_valid[k][pend[i].port] = 1'b1;
                        e_data[k][pend[i].port]  = pend[i].data;
                        e_addr[k][pend[i].port]  = pend[i].addr;
                    end
                end
            end
            while (pend.size() > 0 && pend[0].acc + 4 <= m_cyc) void'(pend.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int k, input string tag,
                            input logic r0, input logic r1, input logic mr, input logic mw,
                            input logic [19:0] ma, input logic [31:0] md,
                            input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [19:0] a0, input logic [19:0] a1);
        logic [1:0] g;
        g = grant_of(p0_read | p0_write, p1_read | p1_write, m_last);
        chk({tag, ".p0_ready"}, 32'(r0), 32'(g[0]));
        chk({tag, ".p1_ready"}, 32'(r1), 32'(g[1]));
        chk({tag, ".mem_read"}, 32'(mr), 32'(e_mem_read));
        chk({tag, ".mem_write"}, 32'(mw), 32'(e_mem_write));
        chk({tag, ".mem_address"}, 32'(ma), 32'(e_mem_address));
        chk({tag, ".mem_in_data"}, md, e_mem_in_data);
        chk({tag, ".p0_valid"}, 32'(v0), 32'(e_valid[k][0]));
        chk({tag, ".p1_valid"}, 32'(v1), 32'(e_valid[k][1]));
        chk({tag, ".p0_out_data"}, d0, e_data[k][0]);
        chk({tag, ".p1_out_data"}, d1, e_data[k][1]);
        chk({tag, ".p0_out_addr"}, 32'(a0), 32'(e_addr[k][0]));
        chk({tag, ".p1_out_addr"}, 32'(a1), 32'(e_addr[k][1]));
    endtask

    always @(negedge clock) begin
        chk_inst(0, "lat1", p0_ready_1, p1_ready_1, mem_read_1, mem_write_1, mem_address_1, mem_in_data_1,
                 p0_valid_1, p1_valid_1, p0_out_data_1, p1_out_data_1, p0_out_addr_1, p1_out_addr_1);
        chk_inst(1, "lat3", p0_ready_3, p1_ready_3, mem_read_3, mem_write_3, mem_address_3, mem_in_data_3,
                 p0_valid_3, p1_valid_3, p0_out_data_3, p1_out_data_3, p0_out_addr_3, p1_out_addr_3);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first1;
        int first3;

        // reset then idle
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(20);
        chk("idle.mem_read", 32'(mem_read_1), 32'd0);
        chk("idle.p0_valid", 32'(p0_valid_1), 32'd0);

        // single port 0 read
        p0_read = 1'b1; p0_address = 20'h00010;
        #1;
        chk("single.p0_ready", 32'(p0_ready_1), 32'd1);
        chk("single.p1_ready", 32'(p1_ready_1), 32'd0);
        tick();
        p0_read = 1'b0; p0_address = '0;
        #1;
        chk("single.mem_read", 32'(mem_read_1), 32'd1);
        chk("single.mem_address", 32'(mem_address_1), 32'h10);
        tick();
        chk("single.mem_read_drop", 32'(mem_read_1), 32'd0);
        chk("single.early_valid", 32'(p0_valid_1), 32'd0);
        tick();
        chk("single.p0_valid", 32'(p0_valid_1), 32'd1);
        chk("single.p0_out_data", p0_out_data_1, 32'hDEAD_BEEF);
        chk("single.p0_out_addr", 32'(p0_out_addr_1), 32'h10);
        chk("single.p1_valid", 32'(p1_valid_1), 32'd0);
        idle(6);

        // write then read-after-write on port 1
        p1_write = 1'b1; p1_address = 20'h00020; p1_in_data = 32'h1234_5678;
        tick();
        chk("raw.mem_write", 32'(mem_write_1), 32'd1);
        chk("raw.mem_in_data", mem_in_data_1, 32'h1234_5678);
        p1_write = 1'b0; p1_read = 1'b1; p1_in_data = '0;
        tick();
        p1_read = 1'b0;
        chk("raw.mem_read", 32'(mem_read_1), 32'd1);
        tick();
        chk("raw.write_no_valid", 32'(p1_valid_1), 32'd0);
        tick();
        chk("raw.p1_valid", 32'(p1_valid_1), 32'd1);
        chk("raw.p1_out_data", p1_out_data_1, 32'h1234_5678);
        idle(6);

        // contention: three reads from each port, alternating grants starting at port 0
        p0_read = 1'b1; p0_address = 20'h4;
        p1_read = 1'b1; p1_address = 20'h8;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("contend.p0_ready", 32'(p0_ready_1), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("contend.p1_ready", 32'(p1_ready_1), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i == 4) p0_read = 1'b0;
        end
        p1_read = 1'b0; p0_address = '0; p1_address = '0;
        idle(8);
        chk("contend.p0_out_data", p0_out_data_1, 32'hA0A0_0004);
        chk("contend.p1_out_data", p1_out_data_1, 32'hB0B0_0008);

        // reset while a read is in flight
        p0_read = 1'b1; p0_address = 20'h10;
        tick();
        p0_read = 1'b0; p0_address = '0;
        reset = 1'b0;
        #1;
        chk("midrst.mem_read", 32'(mem_read_1), 32'd0);
        idle(2);
        reset = 1'b1;
        idle(6);
        p0_read = 1'b1; p0_address = 20'h4;
        p1_read = 1'b1; p1_address = 20'h8;
        #1;
        chk("midrst.p0_ready", 32'(p0_ready_1), 32'd1);
        chk("midrst.p1_ready", 32'(p1_ready_1), 32'd0);
        tick();
        p0_read = 1'b0; p0_address = '0;
        tick();
        p1_read = 1'b0; p1_address = '0;
        idle(8);

        // latency sweep: single port 1 read seen by both instances
        p1_read = 1'b1; p1_address = 20'h8;
        tick();
        p1_read = 1'b0; p1_address = '0;
        first1 = 0;
        first3 = 0;
        for (int n = 1; n <= 12; n++) begin
            if (p1_valid_1 && first1 == 0) first1 = n;
            if (p1_valid_3 && first3 == 0) first3 = n;
            tick();
        end
        chk("sweep.lat1_cycles", 32'(first1), 32'd3);
        chk("sweep.lat3_cycles", 32'(first3), 32'd5);
        chk("sweep.lat3_data", p1_out_data_3, 32'hB0B0_0008);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
